// File: rtl/bp_fe_fetch_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bp_fe_fetch_responder_if: pc_gen fetch and line-refill handshake bundle  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface bp_fe_fetch_responder_if #(
  parameter int eaddr_width_p = 64,
  parameter int instr_width_p = 32
);
  localparam int mem_data_width_lp = 4 * instr_width_p;

  logic [eaddr_width_p-1:0]               pc_gen_icache_i;
  logic                                   pc_gen_icache_v_i;
  logic                                   pc_gen_icache_ready_o;
  logic [instr_width_p+eaddr_width_p-1:0] icache_pc_gen_o;
  logic                                   icache_pc_gen_v_o;
  logic                                   icache_miss_o;
  logic                                   mem_req_v_o;
  logic [eaddr_width_p-1:0]               mem_req_addr_o;
  logic                                   mem_req_ready_i;
  logic                                   mem_resp_v_i;
  logic [mem_data_width_lp-1:0]           mem_resp_data_i;

  // master: pc_gen plus backing memory; slave: the responder
  modport master (
    output pc_gen_icache_i, pc_gen_icache_v_i, mem_req_ready_i, mem_resp_v_i, mem_resp_data_i,
    input  pc_gen_icache_ready_o, icache_pc_gen_o, icache_pc_gen_v_o, icache_miss_o,
           mem_req_v_o, mem_req_addr_o
  );

  modport slave (
    input  pc_gen_icache_i, pc_gen_icache_v_i, mem_req_ready_i, mem_resp_v_i, mem_resp_data_i,
    output pc_gen_icache_ready_o, icache_pc_gen_o, icache_pc_gen_v_o, icache_miss_o,
           mem_req_v_o, mem_req_addr_o
  );
endinterface
`default_nettype wire

// File: rtl/bp_fe_fetch_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bp_fe_fetch_responder: direct-mapped line buffer answering pc_gen fetches |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bp_fe_fetch_responder #(
  parameter int eaddr_width_p = 64,
  parameter int instr_width_p = 32,
  parameter int lines_p       = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  bp_fe_fetch_responder_if.slave   bus
);
  localparam int line_instrs_lp    = 4;
  localparam int mem_data_width_lp = line_instrs_lp * instr_width_p;
  localparam int index_w_lp        = $clog2(lines_p);
  localparam int tag_w_lp          = eaddr_width_p - 4 - index_w_lp;

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_req   = 2'd1,
    e_wait  = 2'd2
  } state_e;

  state_e                        state_r, state_n;
  logic                          s1_v_r;
  logic [eaddr_width_p-1:0]      s1_addr_r;
  logic [eaddr_width_p-1:0]      req_addr_r;
  logic [lines_p-1:0]            valid_r;
  logic [tag_w_lp-1:0]           tag_mem  [lines_p];
  logic [mem_data_width_lp-1:0]  data_mem [lines_p];

  logic [index_w_lp-1:0]         s1_index, fill_index;
  logic [tag_w_lp-1:0]           s1_tag, fill_tag;
  logic [1:0]                    s1_word;
  logic [instr_width_p-1:0]      s1_instr;
  logic                          hit, s1_miss, accept, fill;
  logic                          ready, miss, mem_req_v;

  assign s1_index   = s1_addr_r[4 +: index_w_lp];
  assign s1_tag     = s1_addr_r[eaddr_width_p-1 -: tag_w_lp];
  assign s1_word    = s1_addr_r[3:2];
  assign fill_index = req_addr_r[4 +: index_w_lp];
  assign fill_tag   = req_addr_r[eaddr_width_p-1 -: tag_w_lp];
  assign s1_instr   = data_mem[s1_index][32'(s1_word) * instr_width_p +: instr_width_p];

  // A flush in the lookup cycle wins over a valid line
  assign hit     = valid_r[s1_index] & (tag_mem[s1_index] == s1_tag) & ~flush_i;
  assign s1_miss = s1_v_r & ~hit;
  assign accept  = bus.pc_gen_icache_v_i & ready;
  assign fill    = (state_r == e_wait) & bus.mem_resp_v_i;

  always_comb begin
    state_n   = state_r;
    ready     = 1'b0;
    miss      = 1'b0;
    mem_req_v = 1'b0;
    case (state_r)
      e_ready: begin
        ready = ~s1_miss;
        miss  = s1_miss;
        if (s1_miss) state_n = e_req;
      end
      e_req: begin
        mem_req_v = 1'b1;
        miss      = 1'b1;
        if (bus.mem_req_ready_i) state_n = e_wait;
      end
      e_wait: begin
        miss = 1'b1;
        if (bus.mem_resp_v_i) state_n = e_ready;
      end
      default: state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= e_ready;
      s1_v_r     <= 1'b0;
      s1_addr_r  <= '0;
      req_addr_r <= '0;
      valid_r    <= '0;
    end else begin
      state_r <= state_n;
      s1_v_r  <= accept;
      if (accept) s1_addr_r <= bus.pc_gen_icache_i;
      if (state_r == e_ready && s1_miss)
        req_addr_r <= {s1_addr_r[eaddr_width_p-1:4], 4'b0000};
      // Fill data still lands on a coincident flush, but the line stays invalid
      if (flush_i)   valid_r             <= '0;
      else if (fill) valid_r[fill_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill) begin
      data_mem[fill_index] <= bus.mem_resp_data_i;
      tag_mem[fill_index]  <= fill_tag;
    end
  end

  assign bus.pc_gen_icache_ready_o = ready;
  assign bus.icache_miss_o         = miss;
  assign bus.mem_req_v_o           = mem_req_v;
  assign bus.mem_req_addr_o        = req_addr_r;
  assign bus.icache_pc_gen_v_o     = s1_v_r & hit;
  assign bus.icache_pc_gen_o       = (s1_v_r & hit) ? {s1_instr, s1_addr_r} : '0;

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_fetch_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bp_fe_fetch_responder: directed self-checking bench for the responder |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bp_fe_fetch_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  localparam logic [127:0] LINE_A = 128'h00000013_00C58593_00100093_00000297;

  bp_fe_fetch_responder_if #(.eaddr_width_p(64), .instr_width_p(32)) bus ();

  bp_fe_fetch_responder #(.eaddr_width_p(64), .instr_width_p(32), .lines_p(8)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full miss: request, miss cycle, held mem request, handshake, fill
  task automatic miss_fill(input logic [63:0] a, input logic [63:0] line, input logic [127:0] d,
                           input int hold, input bit fl_req, input bit fl_resp);
    @(negedge clk); bus.pc_gen_icache_i = a; bus.pc_gen_icache_v_i = 1'b1; flush = fl_req; #1;
    chk("accept_ready", 128'(bus.pc_gen_icache_ready_o), 128'(1));
    @(negedge clk); bus.pc_gen_icache_v_i = 1'b0; flush = 1'b0; #1;
    chk("s1_miss", 128'(bus.icache_miss_o), 128'(1));
    chk("s1_miss_no_v", 128'(bus.icache_pc_gen_v_o), 128'(0));
    chk("s1_miss_ready", 128'(bus.pc_gen_icache_ready_o), 128'(0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      chk("held_req_v", 128'(bus.mem_req_v_o), 128'(1));
      chk("held_req_addr", 128'(bus.mem_req_addr_o), 128'(line));
      chk("held_ready", 128'(bus.pc_gen_icache_ready_o), 128'(0));
    end
    @(negedge clk); bus.mem_req_ready_i = 1'b1; #1;
    chk("req_v", 128'(bus.mem_req_v_o), 128'(1));
    chk("req_addr", 128'(bus.mem_req_addr_o), 128'(line));
    @(negedge clk); bus.mem_req_ready_i = 1'b0; #1;
    chk("wait_req_v", 128'(bus.mem_req_v_o), 128'(0));
    chk("wait_miss", 128'(bus.icache_miss_o), 128'(1));
    @(negedge clk); bus.mem_resp_v_i = 1'b1; bus.mem_resp_data_i = d; flush = fl_resp; #1;
    @(negedge clk); bus.mem_resp_v_i = 1'b0; flush = 1'b0; #1;
    chk("refill_ready", 128'(bus.pc_gen_icache_ready_o), 128'(1));
    chk("refill_miss", 128'(bus.icache_miss_o), 128'(0));
  endtask

  task automatic hit_chk(input logic [63:0] a, input logic [31:0] instr);
    @(negedge clk); bus.pc_gen_icache_i = a; bus.pc_gen_icache_v_i = 1'b1; #1;
    @(negedge clk); bus.pc_gen_icache_v_i = 1'b0; #1;
    chk("hit_v", 128'(bus.icache_pc_gen_v_o), 128'(1));
    chk("hit_data", 128'(bus.icache_pc_gen_o), 128'({instr, a}));
    chk("hit_miss", 128'(bus.icache_miss_o), 128'(0));
  endtask

  initial begin
    logic [63:0] seq_addr [4];
    logic [31:0] seq_word [4];
    seq_addr = '{64'h80000120, 64'h80000124, 64'h80000128, 64'h8000012C};
    seq_word = '{32'h00000297, 32'h00100093, 32'h00C58593, 32'h00000013};

    bus.pc_gen_icache_i   = '0;
    bus.pc_gen_icache_v_i = 1'b0;
    bus.mem_req_ready_i   = 1'b0;
    bus.mem_resp_v_i      = 1'b0;
    bus.mem_resp_data_i   = '0;

    // Reset values, then idle
    @(negedge clk); #1;
    chk("rst_v_o", 128'(bus.icache_pc_gen_v_o), 128'(0));
    chk("rst_miss", 128'(bus.icache_miss_o), 128'(0));
    chk("rst_req_v", 128'(bus.mem_req_v_o), 128'(0));
    chk("rst_data", 128'(bus.icache_pc_gen_o), 128'(0));
    chk("rst_req_addr", 128'(bus.mem_req_addr_o), 128'(0));
    @(negedge clk); rst = 1'b0; #1;
    @(negedge clk); #1;
    chk("idle_ready", 128'(bus.pc_gen_icache_ready_o), 128'(1));
    chk("idle_v_o", 128'(bus.icache_pc_gen_v_o), 128'(0));
    chk("idle_miss", 128'(bus.icache_miss_o), 128'(0));
    chk("idle_req_v", 128'(bus.mem_req_v_o), 128'(0));

    // Cold miss, refill, replay
    miss_fill(64'h80000124, 64'h80000120, LINE_A, 0, 1'b0, 1'b0);
    hit_chk(64'h80000124, 32'h00100093);

    // Back-to-back sequential hits
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        bus.pc_gen_icache_i = seq_addr[i];
        bus.pc_gen_icache_v_i = 1'b1;
      end else begin
        bus.pc_gen_icache_v_i = 1'b0;
      end
      #1;
      if (i > 0) begin
        chk("seq_v", 128'(bus.icache_pc_gen_v_o), 128'(1));
        chk("seq_data", 128'(bus.icache_pc_gen_o), 128'({seq_word[i-1], seq_addr[i-1]}));
        chk("seq_miss", 128'(bus.icache_miss_o), 128'(0));
      end
    end

    // Index conflict with long-held memory request
    miss_fill(64'h80000000, 64'h80000000, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 0, 1'b0, 1'b0);
    miss_fill(64'h80000080, 64'h80000080, 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 0, 1'b0, 1'b0);
    hit_chk(64'h80000084, 32'hB1B1B1B1);
    miss_fill(64'h80000000, 64'h80000000, 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0, 5, 1'b0, 1'b0);
    hit_chk(64'h80000008, 32'hC2C2C2C2);

    // Flush coincident with the fill: replay misses again
    miss_fill(64'h80000200, 64'h80000200, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, 0, 1'b0, 1'b1);
    miss_fill(64'h80000200, 64'h80000200, 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0, 0, 1'b0, 1'b0);
    hit_chk(64'h80000204, 32'hE1E1E1E1);

    // Flush in the acceptance cycle makes the lookup miss
    miss_fill(64'h80000208, 64'h80000200, 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0, 0, 1'b1, 1'b0);
    hit_chk(64'h80000208, 32'hF2F2F2F2);

    // Reset while waiting for the fill; a late response must be ignored
    @(negedge clk); bus.pc_gen_icache_i = 64'h80000300; bus.pc_gen_icache_v_i = 1'b1; #1;
    @(negedge clk); bus.pc_gen_icache_v_i = 1'b0; #1;
    chk("rw_miss", 128'(bus.icache_miss_o), 128'(1));
    @(negedge clk); bus.mem_req_ready_i = 1'b1; #1;
    @(negedge clk); bus.mem_req_ready_i = 1'b0; #1;
    chk("rw_wait", 128'(bus.icache_miss_o), 128'(1));
    @(negedge clk); rst = 1'b1; #1;
    chk("rw_rst_miss", 128'(bus.icache_miss_o), 128'(0));
    chk("rw_rst_req_v", 128'(bus.mem_req_v_o), 128'(0));
    @(negedge clk); rst = 1'b0; #1;
    @(negedge clk); bus.mem_resp_v_i = 1'b1; bus.mem_resp_data_i = '1; #1;
    chk("stale_v_o", 128'(bus.icache_pc_gen_v_o), 128'(0));
    @(negedge clk); bus.mem_resp_v_i = 1'b0; #1;
    chk("stale_ready", 128'(bus.pc_gen_icache_ready_o), 128'(1));
    chk("stale_v_o2", 128'(bus.icache_pc_gen_v_o), 128'(0));
    miss_fill(64'h80000300, 64'h80000300, 128'h13131313_12121212_11111111_10101010, 0, 1'b0, 1'b0);
    hit_chk(64'h8000030C, 32'h13131313);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
